// File: rtl/aes_dec_engine.sv
// Iterative AES inverse cipher (NR = 10/12/14): one round per cycle, round keys fetched by index.
// Define AES_CBC_EN to add the CBC chaining register (iv_load/iv_data); otherwise pure ECB.
module aes_dec_engine #(
  parameter int NR = 10,
  parameter int KW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  output logic [KW-1:0]  rk_idx,
  input  logic [127:0]   rk_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data,
  output logic           busy,
  input  logic           iv_load,
  input  logic [127:0]   iv_data
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_dec_engine: NR must be 10, 12 or 14");
  end
  if ((2 ** KW) <= NR) begin : g_bad_kw
    $error("aes_dec_engine: KW too narrow to index round key NR");
  end

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [2:0] {IDLE, FIRST, ROUND, LAST, DONE} state_t;

  state_t          state_q, state_d;
  logic [127:0]    s_q;
  logic [KW-1:0]   rc_q;
  logic            accept;
  logic [127:0]    key_mix;
  logic [127:0]    round_out;
  logic [127:0]    last_out;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] base;
    base = 11'h7ff - {b, 3'b000};
    return INV_SBOX[base -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] a);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_sbox(a[127-8*i -: 8]);
    return r;
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] a);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = a[127-8*(4*((c-w)&3)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] a);
    logic [127:0] r;
    logic [7:0]   v [4];
    logic [7:0]   m2 [4];
    logic [7:0]   m4 [4];
    logic [7:0]   m8 [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        v[w]  = a[127-8*(4*c+w) -: 8];
        m2[w] = xt(v[w]);
        m4[w] = xt(m2[w]);
        m8[w] = xt(m4[w]);
        m9[w] = m8[w] ^ v[w];
        mb[w] = m8[w] ^ m2[w] ^ v[w];
        md[w] = m8[w] ^ m4[w] ^ v[w];
        me[w] = m8[w] ^ m4[w] ^ m2[w];
      end
      r[127-8*(4*c+0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return r;
  endfunction

  // FIRST skips InvMixColumns; every later round applies it after the key add.
  assign key_mix   = s_q ^ rk_data;
  assign round_out = inv_sub_bytes(inv_shift_rows((state_q == FIRST) ? key_mix
                                                  : inv_mix_columns(key_mix)));
  assign accept    = (state_q == IDLE) && in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = '0;
    case (state_q)
      IDLE: begin
`ifdef AES_CBC_EN
        in_ready = !iv_load;
`else
        in_ready = 1'b1;
`endif
        if (in_valid && in_ready) state_d = FIRST;
      end
      FIRST: begin
        busy    = 1'b1;
        rk_idx  = KW'(NR);
        state_d = ROUND;
      end
      ROUND: begin
        busy   = 1'b1;
        rk_idx = rc_q;
        if (rc_q == KW'(1)) state_d = LAST;
      end
      LAST: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      rc_q     <= '0;
      out_data <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          s_q  <= in_data;
          rc_q <= KW'(NR - 1);
        end
        FIRST: s_q <= round_out;
        ROUND: begin
          s_q  <= round_out;
          rc_q <= rc_q - KW'(1);
        end
        LAST: out_data <= last_out;
        default: ;
      endcase
    end
  end

`ifdef AES_CBC_EN
  logic [127:0] chain_q;
  logic [127:0] ct_hold_q;

  // The chain picks up this block's ciphertext as the plaintext leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q   <= '0;
      ct_hold_q <= '0;
    end else begin
      if (state_q == IDLE && iv_load) chain_q <= iv_data;
      else if (state_q == LAST)       chain_q <= ct_hold_q;
      if (accept) ct_hold_q <= in_data;
    end
  end

  assign last_out = key_mix ^ chain_q;
`else
  logic unused_iv;
  assign unused_iv = ^{iv_load, iv_data};
  assign last_out  = key_mix;
`endif

endmodule

// File: tb/tb_aes_dec_engine.sv
// Randomized bench for aes_dec_engine (NR=10 and NR=14 instances) against a byte-level AES model.
// Honours AES_CBC_EN the same way as the design build.
module tb_aes_dec_engine;

  logic clk = 1'b0;
  logic         rst       [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [127:0] in_data   [2];
  logic [3:0]   rk_idx    [2];
  logic [127:0] rk_data   [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] out_data  [2];
  logic         busy      [2];
  logic         iv_load   [2];
  logic [127:0] iv_data   [2];

  logic [127:0] rkeys [2][16];
  logic [127:0] chainModel [2];
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rk_data[0] = rkeys[0][rk_idx[0]];
  assign rk_data[1] = rkeys[1][rk_idx[1]];

  aes_dec_engine #(.NR(10), .KW(4)) u_dec10 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .rk_idx(rk_idx[0]), .rk_data(rk_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]), .iv_load(iv_load[0]), .iv_data(iv_data[0])
  );

  aes_dec_engine #(.NR(14), .KW(4)) u_dec14 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .rk_idx(rk_idx[1]), .rk_data(rk_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]), .iv_load(iv_load[1]), .iv_data(iv_data[1])
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Carry-less product, then reduce modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  task automatic buildSboxes();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; nk = 4 or 8 words.
  task automatic setKey(input int d, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nr;
    nr = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rkeys[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Textbook inverse cipher over a 16-byte array, round keys from the key store.
  function automatic logic [127:0] invCipher(input int d, input logic [127:0] ct);
    logic [7:0]   st  [16];
    logic [7:0]   tmp [16];
    logic [7:0]   col [4];
    logic [7:0]   coef [4];
    logic [127:0] k;
    logic [127:0] res;
    int nr;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    nr = (d == 0) ? 10 : 14;
    k = rkeys[d][nr];
    for (int i = 0; i < 16; i++) st[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) tmp[4*c+w] = st[4*((c - w + 4) % 4) + w];
      k = rkeys[d][r];
      for (int i = 0; i < 16; i++) st[i] = isbox[tmp[i]] ^ k[127-8*i -: 8];
      if (r > 0)
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) col[j] = st[4*c+j];
          for (int w = 0; w < 4; w++) begin
            st[4*c+w] = 8'h00;
            for (int j = 0; j < 4; j++) st[4*c+w] = st[4*c+w] ^ gmul(coef[(j - w + 4) % 4], col[j]);
          end
        end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one block, follow it through every round, hold off the consumer, then take it.
  task automatic applyStimulus(input int d, input logic [127:0] ct, input logic [127:0] exp,
                               input int hold, input bit withIv, input logic [127:0] iv);
    int nr;
    int cyc;
    int expWait;
    nr = (d == 0) ? 10 : 14;
    cyc = 0;
    expWait = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = ct;
    iv_load[d]  = withIv;
    iv_data[d]  = iv;
    #1;
`ifdef AES_CBC_EN
    if (withIv) begin
      checkOutput("iv_gates_in_ready", 128'(in_ready[d]), 128'(0));
      expWait = 1;
      chainModel[d] = iv;
    end
`else
    if (withIv) checkOutput("iv_load_ignored", 128'(in_ready[d]), 128'(1));
`endif
    while (!in_ready[d] && cyc < 40) begin
      @(negedge clk);
      iv_load[d] = 1'b0;
      #1;
      cyc++;
    end
    checkOutput("accept_wait", 128'(cyc), 128'(expWait));
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    iv_load[d]  = 1'b0;
    in_data[d]  = rand128();
    for (int k = 1; k <= nr + 2; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= nr + 1) begin
        checkOutput("rk_idx", 128'(rk_idx[d]), 128'(nr - (k - 1)));
        checkOutput("busy", 128'(busy[d]), 128'(1));
      end
      checkOutput("out_valid_timing", 128'(out_valid[d]), 128'(k == nr + 2));
    end
    for (int h = 0; h < hold; h++) begin
      checkOutput("hold_valid", 128'(out_valid[d]), 128'(1));
      checkOutput("hold_data", out_data[d], exp);
      checkOutput("hold_in_ready", 128'(in_ready[d]), 128'(0));
      @(negedge clk);
    end
    out_ready[d] = 1'b1;
    checkOutput("out_data", out_data[d], exp);
    checkOutput("handshake_in_ready", 128'(in_ready[d]), 128'(0));
    @(negedge clk);
    out_ready[d] = 1'b0;
    #1;
    checkOutput("valid_drop", 128'(out_valid[d]), 128'(0));
    checkOutput("ready_return", 128'(in_ready[d]), 128'(1));
`ifdef AES_CBC_EN
    chainModel[d] = ct;
`endif
  endtask

  task automatic resetMidway(input int d, input logic [127:0] ct);
    int cyc;
    int seen;
    cyc = 0;
    seen = 0;
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_data[d]  = ct;
    while (!in_ready[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    repeat (4) @(negedge clk);
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    chainModel[d] = '0;
    checkOutput("rst_in_ready", 128'(in_ready[d]), 128'(1));
    checkOutput("rst_out_valid", 128'(out_valid[d]), 128'(0));
    checkOutput("rst_busy", 128'(busy[d]), 128'(0));
    checkOutput("rst_rk_idx", 128'(rk_idx[d]), 128'(0));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid[d]) seen++;
    end
    checkOutput("rst_no_output", 128'(seen), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] ct;
    logic [127:0] exp;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      in_valid[d] = 1'b0;
      in_data[d] = '0;
      out_ready[d] = 1'b0;
      iv_load[d] = 1'b0;
      iv_data[d] = '0;
      chainModel[d] = '0;
      for (int r = 0; r < 16; r++) rkeys[d][r] = '0;
    end
    buildSboxes();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_in_ready", 128'(in_ready[d]), 128'(1));
      checkOutput("reset_out_valid", 128'(out_valid[d]), 128'(0));
      checkOutput("reset_busy", 128'(busy[d]), 128'(0));
      checkOutput("reset_rk_idx", 128'(rk_idx[d]), 128'(0));
      checkOutput("reset_out_data", out_data[d], 128'(0));
      rst[d] = 1'b0;
    end
    @(negedge clk);

    setKey(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    applyStimulus(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff, 5, 1'b0, '0);
    for (int n = 0; n < 4; n++) begin
      setKey(0, {rand128(), 128'h0}, 4);
      ct  = rand128();
      exp = invCipher(0, ct) ^ chainModel[0];
      applyStimulus(0, ct, exp, int'($urandom_range(0, 3)), 1'b0, '0);
    end

    resetMidway(0, rand128());
    setKey(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    applyStimulus(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff, 0, 1'b0, '0);

`ifdef AES_CBC_EN
    setKey(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    applyStimulus(0, 128'h7649abac8119b246cee98e9b12e9197d,
                  128'h6bc1bee22e409f96e93d7e117393172a, 0, 1'b1,
                  128'h000102030405060708090a0b0c0d0e0f);
    applyStimulus(0, 128'h5086cb9b507219ee95db113a917678b2,
                  128'hae2d8a571e03ac9c9eb76fac45af8e51, 2, 1'b0, '0);
`else
    applyStimulus(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff, 1, 1'b1, rand128());
`endif

    setKey(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    applyStimulus(1, 128'h8ea2b7ca516745bfeafc49904b496089,
                  128'h00112233445566778899aabbccddeeff, 3, 1'b0, '0);
    for (int n = 0; n < 3; n++) begin
      setKey(1, {rand128(), rand128()}, 8);
      ct  = rand128();
      exp = invCipher(1, ct) ^ chainModel[1];
      applyStimulus(1, ct, exp, int'($urandom_range(0, 2)), 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
